// File: rtl/nibble_add_seq.sv
// rtl/nibble_add_seq.sv - WIDTH-bit adder sequenced one nibble per clock through a shared 4-bit slice (optional NIBBLE_ADD_SEQ_OVF_EN adds signed overflow output ovf)
module nibble_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done,
    output logic [3:0]       sx,
    output logic [3:0]       sy,
    output logic             scin,
    input  logic [3:0]       ss,
    input  logic             scout
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [IDXW-1:0]   idx;
    logic              carry;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [3:0]        a_nib;
    logic [3:0]        b_nib;
    logic              last;

    assign last = (idx == IDXW'(NIBBLES - 1));

    // State register; reset aborts any operation in flight
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Select the current operand nibbles from the captured operands only
    always_comb begin
        a_nib = 4'h0;
        b_nib = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDXW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    // Next state plus handshake and slice drive, all decoded from registered state
    always_comb begin
        state_n = state;
        ready   = 1'b0;
        done    = 1'b0;
        sx      = 4'h0;
        sy      = 4'h0;
        scin    = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                sx   = a_nib;
                sy   = b_nib;
                scin = carry;
                if (last) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Operand capture, per-nibble result write-back and carry chaining
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            idx   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= cin;
                        idx   <= '0;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx == IDXW'(i)) begin
                            sum[4*i +: 4] <= ss;
                        end
                    end
                    carry <= scout;
                    if (last) begin
                        cout <= scout;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
                        ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (ss[3] != a_q[WIDTH-1]);
`endif
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
